// File: rtl/vl_pipe_elastic_pkg.sv
// Shared constants and helpers for the elastic delay pipeline.
package vl_pipe_pkg;

    // Advance modes
    localparam int MODE_RIGID    = 0;
    localparam int MODE_COLLAPSE = 1;

    // Width of a counter able to hold 0..depth
    function automatic int occ_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/vl_pipe_elastic_if.sv
// Upstream and downstream valid/ready handshake of the elastic pipeline.
interface vl_pipe_elastic_if #(
    parameter int DW = 8
);
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;

    // Producer/consumer side (drives words in, takes words out)
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    // Pipeline side
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/vl_pipe_elastic_slice.sv
// One register stage: a data word plus its valid bit.
module vl_pipe_slice #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic          load,
    input  logic          src_valid,
    input  logic [DW-1:0] src_data,
    input  logic          drain,
    output logic          valid,
    output logic [DW-1:0] data
);

    // Flush drops the valid bit only; data is kept to avoid a wide clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (clr) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= src_valid;
            data  <= src_data;
        end else if (drain) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/vl_pipe_elastic.sv
// Elastic delay pipeline: PIPE_DEPTH stages with valid/ready on both ends,
// bubble-collapsing or rigid lock-step advance, flush and occupancy count.
module vl_pipe_elastic
    import vl_pipe_pkg::*;
#(
    parameter int PIPE_DEPTH = 2,
    parameter int PIPE_DW    = 8,
    parameter int COLLAPSE   = MODE_COLLAPSE,
    localparam int CW        = occ_w(PIPE_DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    vl_pipe_elastic_if.slave bus,
    output logic [CW-1:0] occupancy
);

    if (PIPE_DEPTH < 1) begin : g_bad_depth
        $fatal(1, "vl_pipe_elastic: PIPE_DEPTH must be at least 1");
    end
    if (COLLAPSE != MODE_RIGID && COLLAPSE != MODE_COLLAPSE) begin : g_bad_mode
        $fatal(1, "vl_pipe_elastic: COLLAPSE must be 0 or 1");
    end

    logic [PIPE_DEPTH-1:0]              valid, rdy, down_rdy, load, drain, src_valid;
    logic [PIPE_DEPTH-1:0][PIPE_DW-1:0] data, src_data;
    logic                               in_xfer, out_xfer;

    assign bus.in_ready  = ~clr & rdy[PIPE_DEPTH-1];
    assign bus.out_valid = valid[0] & ~clr;
    assign bus.out_data  = data[0];
    assign in_xfer       = bus.in_valid & bus.in_ready;
    assign out_xfer      = bus.out_valid & bus.out_ready;

    for (genvar k = 0; k < PIPE_DEPTH; k++) begin : g_stage
        // Source of each stage: upstream neighbour, or the input port at the top
        if (k == PIPE_DEPTH - 1) begin : g_src_in
            // Rigid mode shifts bubbles in too, so it needs the qualified transfer
            assign src_valid[k] = (COLLAPSE == MODE_COLLAPSE) ? bus.in_valid : in_xfer;
            assign src_data[k]  = bus.in_data;
        end else begin : g_src_up
            assign src_valid[k] = valid[k+1];
            assign src_data[k]  = data[k+1];
        end

        if (k == 0) begin : g_down_out
            assign down_rdy[k] = bus.out_ready;
        end else begin : g_down_stage
            assign down_rdy[k] = rdy[k-1];
        end

        if (COLLAPSE == MODE_COLLAPSE) begin : g_collapse
            // Ready when empty or when the current word moves on this cycle
            assign rdy[k]   = ~valid[k] | down_rdy[k];
            assign load[k]  = rdy[k] & src_valid[k];
            assign drain[k] = rdy[k];
        end else begin : g_rigid
            // Every stage shares the single advance condition
            assign rdy[k]   = ~valid[0] | bus.out_ready;
            assign load[k]  = rdy[k];
            assign drain[k] = 1'b0;
        end

        vl_pipe_slice #(.DW(PIPE_DW)) u_slice (
            .clk       (clk),
            .reset     (reset),
            .clr       (clr),
            .load      (load[k]),
            .src_valid (src_valid[k]),
            .src_data  (src_data[k]),
            .drain     (drain[k]),
            .valid     (valid[k]),
            .data      (data[k])
        );
    end

    // Occupancy tracks transfers so it always matches the valid-bit popcount
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            occupancy <= '0;
        end else if (in_xfer && !out_xfer) begin
            occupancy <= occupancy + CW'(1);
        end else if (out_xfer && !in_xfer) begin
            occupancy <= occupancy - CW'(1);
        end
    end

endmodule

// File: tb/tb_vl_pipe_elastic.sv
// Bench for vl_pipe_elastic: one collapsing and one rigid instance driven
// with the same handshake pattern, each compared against its own model.
module tb_vl_pipe_elastic;
    localparam int D  = 3;
    localparam int DW = 8;
    localparam int CW = $clog2(D + 1);

    logic clk = 1'b0;
    logic reset, clr;
    logic [CW-1:0] occ_c, occ_r;

    always #5 clk = ~clk;

    vl_pipe_elastic_if #(.DW(DW)) bus_c ();
    vl_pipe_elastic_if #(.DW(DW)) bus_r ();

    vl_pipe_elastic #(.PIPE_DEPTH(D), .PIPE_DW(DW), .COLLAPSE(1)) u_c (
        .clk(clk), .reset(reset), .clr(clr), .bus(bus_c), .occupancy(occ_c));
    vl_pipe_elastic #(.PIPE_DEPTH(D), .PIPE_DW(DW), .COLLAPSE(0)) u_r (
        .clk(clk), .reset(reset), .clr(clr), .bus(bus_r), .occupancy(occ_r));

    int n_chk = 0, n_fail = 0;

    // Collapsing model: queued words with the stage each one sits in
    logic [7:0] cq[$];
    int         cp[$];
    // Rigid model: time slots marching in lock-step, slot 0 at the output
    bit         rv[D];
    logic [7:0] seq_c, seq_r, r_next;
    int         n_in_c, n_out_c, n_out_r;
    logic       last_ov_c;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One cycle: drive at negedge, check settled outputs, advance the models
    task automatic step(input bit iv, input bit ordy, input bit cl);
        bit eov, eir, adv;
        int prev, np, ro;
        @(negedge clk);
        clr             = cl;
        bus_c.in_valid  = iv;
        bus_c.in_data   = seq_c;
        bus_c.out_ready = ordy;
        bus_r.in_valid  = iv;
        bus_r.in_data   = seq_r;
        bus_r.out_ready = ordy;
        #1;
        // collapsing instance
        eov = !cl && cq.size() > 0 && cp[0] == 0;
        eir = !cl && (cq.size() < D || ordy);
        last_ov_c = bus_c.out_valid;
        chk("c_out_valid", 32'(bus_c.out_valid), 32'(eov));
        if (eov) chk("c_out_data", 32'(bus_c.out_data), 32'(cq[0]));
        chk("c_in_ready", 32'(bus_c.in_ready), 32'(eir));
        chk("c_occupancy", 32'(occ_c), 32'(cq.size()));
        if (bus_c.out_valid === 1'b1 && ordy) n_out_c++;
        if (bus_c.in_ready === 1'b1 && iv) n_in_c++;
        if (cl) begin
            cq.delete();
            cp.delete();
        end else begin
            if (eov && ordy) begin
                void'(cq.pop_front());
                void'(cp.pop_front());
            end
            // each word drops one stage if the stage below ends up free
            prev = -1;
            foreach (cp[i]) begin
                np = (cp[i] - 1 > prev) ? cp[i] - 1 : cp[i];
                cp[i] = np;
                prev = np;
            end
            if (iv && eir) begin
                cq.push_back(seq_c);
                cp.push_back(D - 1);
                seq_c++;
            end
        end
        // rigid instance
        adv = !rv[0] || ordy;
        eov = !cl && rv[0];
        eir = !cl && adv;
        ro = 0;
        foreach (rv[k]) ro += int'(rv[k]);
        chk("r_out_valid", 32'(bus_r.out_valid), 32'(eov));
        chk("r_in_ready", 32'(bus_r.in_ready), 32'(eir));
        chk("r_occupancy", 32'(occ_r), 32'(ro));
        if (bus_r.out_valid === 1'b1 && ordy) begin
            chk("r_order", 32'(bus_r.out_data), 32'(r_next));
            r_next++;
            n_out_r++;
        end
        if (cl) begin
            foreach (rv[k]) rv[k] = 1'b0;
            r_next = seq_r;
        end else if (adv) begin
            for (int k = 0; k < D - 1; k++) rv[k] = rv[k+1];
            rv[D-1] = iv && eir;
            if (iv && eir) seq_r++;
        end
    endtask

    task automatic drain();
        repeat (D + 3) step(1'b0, 1'b1, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        clr   = 1'b0;
        bus_c.in_valid = 1'b0; bus_c.out_ready = 1'b0; bus_c.in_data = '0;
        bus_r.in_valid = 1'b0; bus_r.out_ready = 1'b0; bus_r.in_data = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_c_ov", 32'(bus_c.out_valid), 32'd0);
        chk("rst_c_od", 32'(bus_c.out_data), 32'd0);
        chk("rst_c_occ", 32'(occ_c), 32'd0);
        chk("rst_c_ir", 32'(bus_c.in_ready), 32'd1);
        chk("rst_r_ov", 32'(bus_r.out_valid), 32'd0);
        chk("rst_r_od", 32'(bus_r.out_data), 32'd0);
        chk("rst_r_occ", 32'(occ_r), 32'd0);
        chk("rst_r_ir", 32'(bus_r.in_ready), 32'd1);
        cq.delete();
        cp.delete();
        foreach (rv[k]) rv[k] = 1'b0;
        r_next = seq_r;
    endtask

    initial begin
        int first, b, base_out, base_in, cyc;
        reset = 1'b1; clr = 1'b0;
        bus_c.in_valid = 1'b0; bus_c.out_ready = 1'b0; bus_c.in_data = '0;
        bus_r.in_valid = 1'b0; bus_r.out_ready = 1'b0; bus_r.in_data = '0;
        seq_c = 8'h01; seq_r = 8'h01; r_next = 8'h01;
        n_in_c = 0; n_out_c = 0; n_out_r = 0; last_ov_c = 1'b0;

        do_reset();

        // streaming 0x01..0x0A with out_ready held high
        first = -1;
        for (int i = 0; i < 14; i++) begin
            step(i < 10, 1'b1, 1'b0);
            if (last_ov_c && first < 0) first = i;
        end
        chk("stream_latency", 32'(first), 32'd3);
        chk("stream_count", 32'(n_out_c), 32'd10);

        // stall fill: A0, bubble, A1, A2 with the output blocked
        drain();
        seq_c = 8'hA0; seq_r = 8'hA0; r_next = 8'hA0;
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        chk("fill_occ", 32'(occ_c), 32'd3);
        chk("fill_block", 32'(bus_c.in_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 1'b0);
            chk("fill_nogap", 32'(bus_c.out_valid), 32'd1);
        end
        drain();

        // rigid bubble: 0x10, idle, 0x11 with out_ready toggling
        seq_c = 8'h10; seq_r = 8'h10; r_next = 8'h10;
        b = n_out_r;
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b0, (i % 2) == 0, 1'b0);
        chk("rbub_count", 32'(n_out_r - b), 32'd2);
        drain();

        // flush with two words held, in_valid and out_ready both high
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        b = n_out_c;
        step(1'b1, 1'b1, 1'b1);
        chk("flush_c_ir", 32'(bus_c.in_ready), 32'd0);
        chk("flush_c_ov", 32'(bus_c.out_valid), 32'd0);
        step(1'b0, 1'b0, 1'b0);
        chk("flush_c_occ", 32'(occ_c), 32'd0);
        chk("flush_r_occ", 32'(occ_r), 32'd0);
        chk("flush_c_noxfer", 32'(n_out_c - b), 32'd0);

        // simultaneous in/out transfer on a full collapsing pipe
        repeat (4) step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        chk("simul_ir", 32'(bus_c.in_ready), 32'd1);
        chk("simul_ov", 32'(bus_c.out_valid), 32'd1);
        step(1'b0, 1'b0, 1'b0);
        chk("simul_occ", 32'(occ_c), 32'd3);
        drain();

        // random stall traffic, 10k words through the collapsing pipe
        base_out = n_out_c;
        base_in  = n_in_c;
        cyc = 0;
        while (n_out_c - base_out < 10000 && cyc < 40000) begin
            step(($urandom % 4) != 0, ($urandom % 3) != 0, 1'b0);
            cyc++;
        end
        chk("rand_budget", 32'(n_out_c - base_out >= 10000), 32'd1);
        drain();
        chk("rand_c_loss", 32'(n_out_c - base_out), 32'(n_in_c - base_in));
        chk("rand_c_empty", 32'(occ_c), 32'd0);
        chk("rand_r_empty", 32'(occ_r), 32'd0);
        chk("rand_r_order", 32'(r_next), 32'(seq_r));

        $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
        $finish;
    end

endmodule
